uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
//
// PURPOSE
// Buffered, runtime-configurable UART transmitter; next generation of the single-byte TX.
// Words are queued in an internal FIFO through a valid/ready handshake.
// A frame engine serialises them LSB first with optional parity and 1 or 2 stop bits.
// Bit timing comes from a runtime divisor input.
// Sits between a bus/CPU-side producer and the chip's txd pad.
//
// PARAMETERS
// DATA_W      8     data bits per frame, legal 5..9
// FIFO_DEPTH  16    FIFO words, power of 2, >= 2
// DIV_W       16    width of cfg_divisor
//
// PORTS
// clk          in   1                      system clock
// rst          in   1                      asynchronous reset, active-high
// cfg_divisor  in   DIV_W                  clk cycles per bit; values 0 and 1 are treated as 2
// cfg_parity   in   2                      00 none, 01 even, 10 odd, 11 none
// cfg_stop2    in   1                      0: one stop bit, 1: two stop bits
// tx_data      in   DATA_W                 word to queue
// tx_valid     in   1                      producer offers tx_data
// tx_ready     out  1                      FIFO can accept; equals ~full
// fifo_level   out  $clog2(FIFO_DEPTH)+1   words currently queued
// tx_busy      out  1                      engine not IDLE, or FIFO not empty
// txd          out  1                      serial line, idle high, registered
//
// BEHAVIOUR
// - Reset (async, any time): FIFO emptied; engine forced to IDLE; bit timer cleared.
//   Outputs: txd=1, tx_busy=0, fifo_level=0, tx_ready=1. A frame in flight is aborted;
//   the line returns high immediately. No word survives reset.
// - Push: on a clk edge with tx_valid & tx_ready, tx_data is written and fifo_level increments.
//   tx_ready depends only on full, never on a same-cycle pop, so it is ~full.
//   When full, tx_valid is ignored and data is dropped only if the producer ignores tx_ready.
// - Pop: engine in IDLE with FIFO non-empty pops the head on that edge.
//   On the same edge it latches cfg_divisor/cfg_parity/cfg_stop2 into frame registers,
//   drives txd<=0 and enters START. Config changes mid-frame have no effect until the next frame.
// - Simultaneous push and pop: both occur; fifo_level is unchanged.
//   Push into an empty FIFO is not visible to the engine until the following edge.
// - Latency: a word accepted at edge N into an empty FIFO with the engine IDLE pops at edge N+1.
//   txd goes low after N+1.
// - Bit timer: loaded with D-1 at every bit boundary, where D = max(latched divisor, 2).
//   It decrements each clk; the bit ends when it reads 0. Every bit lasts exactly D cycles.
// - States:
//   IDLE   -> START                       when FIFO non-empty
//   START  -> DATA                        after D cycles
//   DATA   -> PARITY (if parity enabled) or STOP   after DATA_W bits, LSB first
//   PARITY -> STOP
//   STOP   -> IDLE                        after 1 or 2 stop bits (txd=1)
// - Back-to-back frames: at the final stop-bit boundary, if the FIFO is non-empty, the engine
//   pops directly (STOP->START, txd<=0). There are zero idle cycles between frames.
// - Parity: even = XOR of the DATA_W data bits; odd = its inverse.
// - Frame length: 1 + DATA_W + (parity ? 1 : 0) + (stop2 ? 2 : 1) bits.
// - txd changes only at bit boundaries and on reset; it is glitch-free (flop output).
// - tx_busy falls on the edge where the engine enters IDLE with an empty FIFO.
//   That is D cycles after the last stop bit begins.
//
// TESTING
// 1. Reset, divisor=4, no parity, 1 stop; push 0xA5 -> txd low for 4 clk, then bits 1,0,1,0,0,1,0,1
//    (4 clk each), then high. tx_busy deasserts exactly 40 clk after the start bit begins.
// 2. parity=even, then odd, stop2=1, divisor=3; send 0x07 -> parity bit 1 (even) / 0 (odd).
//    Two 3-clk stop bits; 12-bit frame = 36 clk.
// 3. Push FIFO_DEPTH+2 words back-to-back with tx_valid held -> tx_ready drops when level hits
//    FIFO_DEPTH. All words are sent in order with no idle gap between frames.
//    No word is lost or duplicated.
// 4. Change cfg_divisor 4->8 and cfg_parity mid-frame -> the current frame keeps divisor 4 and
//    its parity. The next frame uses 8-clk bits.
// 5. Assert rst in the middle of a DATA bit with 3 words queued -> txd=1 and fifo_level=0
//    immediately. After release, a newly pushed word transmits normally.
// 6. cfg_divisor=0 and 1 -> every bit lasts 2 clk. Push and pop in the same cycle at level 1 ->
//    level stays 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO feeds a frame engine that serialises words
// LSB first with optional parity and one or two stop bits at a runtime bit period.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              cfg_divisor,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_busy,
    output logic                          txd
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int BCW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     count;
    logic              full, empty, push, pop;
    logic [DATA_W-1:0] head;

    state_t            state, state_n;
    logic [DIV_W-1:0]  timer, div_q, div_eff;
    logic [BCW-1:0]    bit_cnt;
    logic [DATA_W-1:0] sh;
    logic              par_bit, par_en, stop2_q, stop_cnt, txd_q;
    logic              txd_n, tick, reload, shift, bit_clr, bit_inc, stop_clr, stop_set;

    assign full       = (count == LW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign push       = tx_valid & ~full;
    assign head       = mem[rd_ptr];
    assign tx_ready   = ~full;
    assign fifo_level = count;
    assign tx_busy    = (state != IDLE) | ~empty;
    assign txd        = txd_q;
    assign tick       = (timer == '0);
    assign div_eff    = (cfg_divisor < DIV_W'(2)) ? DIV_W'(2) : cfg_divisor;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        txd_n    = txd_q;
        pop      = 1'b0;
        reload   = 1'b0;
        shift    = 1'b0;
        bit_clr  = 1'b0;
        bit_inc  = 1'b0;
        stop_clr = 1'b0;
        stop_set = 1'b0;
        case (state)
            IDLE: pop = ~empty;
            START: if (tick) begin
                state_n = DATA;
                txd_n   = sh[0];
                shift   = 1'b1;
                bit_clr = 1'b1;
                reload  = 1'b1;
            end
            DATA: if (tick) begin
                reload = 1'b1;
                if (bit_cnt == BCW'(DATA_W - 1)) begin
                    if (par_en) begin
                        state_n = PARITY;
                        txd_n   = par_bit;
                    end else begin
                        state_n  = STOP;
                        txd_n    = 1'b1;
                        stop_clr = 1'b1;
                    end
                end else begin
                    txd_n   = sh[0];
                    shift   = 1'b1;
                    bit_inc = 1'b1;
                end
            end
            PARITY: if (tick) begin
                state_n  = STOP;
                txd_n    = 1'b1;
                stop_clr = 1'b1;
                reload   = 1'b1;
            end
            STOP: if (tick) begin
                if (stop2_q && !stop_cnt) begin
                    stop_set = 1'b1;
                    reload   = 1'b1;
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Popping always starts a frame, whether from IDLE or straight out of STOP.
        if (pop) begin
            state_n = START;
            txd_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd_q    <= 1'b1;
            timer    <= '0;
            div_q    <= DIV_W'(2);
            bit_cnt  <= '0;
            sh       <= '0;
            par_bit  <= 1'b0;
            par_en   <= 1'b0;
            stop2_q  <= 1'b0;
            stop_cnt <= 1'b0;
        end else begin
            txd_q <= txd_n;
            if (pop) begin
                sh      <= head;
                div_q   <= div_eff;
                timer   <= div_eff - DIV_W'(1);
                par_en  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                par_bit <= (^head) ^ (cfg_parity == 2'b10);
                stop2_q <= cfg_stop2;
            end else begin
                if (reload)          timer <= div_q - DIV_W'(1);
                else if (!tick)      timer <= timer - DIV_W'(1);
                if (shift)           sh    <= sh >> 1;
            end
            if (bit_clr)      bit_cnt <= '0;
            else if (bit_inc) bit_cnt <= bit_cnt + BCW'(1);
            if (stop_clr)      stop_cnt <= 1'b0;
            else if (stop_set) stop_cnt <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based line model checked every cycle, plus
// hand-computed frame waveforms for the directed cases.
module tb_uart_tx_fifo;
    localparam int DATA_W = 8, FIFO_DEPTH = 16, DIV_W = 16;

    logic                        clk = 0, rst = 1;
    logic [DIV_W-1:0]            cfg_divisor = 4;
    logic [1:0]                  cfg_parity = 0;
    logic                        cfg_stop2 = 0;
    logic [DATA_W-1:0]           tx_data = 0;
    logic                        tx_valid = 0;
    logic                        tx_ready, tx_busy, txd;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .cfg_divisor(cfg_divisor), .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_level(fifo_level), .tx_busy(tx_busy), .txd(txd)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0, max_lvl = 0;
    bit saw_full = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: queued words, and the txd value expected on each cycle of the frame in flight.
    logic [DATA_W-1:0] m_fifo[$];
    logic              m_line[$];
    bit                m_full;

    function automatic void add_frame(logic [DATA_W-1:0] w, int div, logic [1:0] par, logic s2);
        logic bits[$];
        int d = (div < 2) ? 2 : div;
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(w[i]);
        if (par == 2'b01) bits.push_back(^w);
        if (par == 2'b10) bits.push_back(~^w);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i]) for (int k = 0; k < d; k++) m_line.push_back(bits[i]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            m_line.delete();
        end else begin
            m_full = (m_fifo.size() == FIFO_DEPTH);
            if (m_line.size() > 0) void'(m_line.pop_front());
            if (m_line.size() == 0 && m_fifo.size() > 0)
                add_frame(m_fifo.pop_front(), int'(cfg_divisor), cfg_parity, cfg_stop2);
            if (tx_valid && !m_full) m_fifo.push_back(tx_data);
            #1;
            if (!rst) begin
                chk("txd", txd, (m_line.size() > 0) ? m_line[0] : 1'b1);
                chk("tx_busy", tx_busy, (m_line.size() > 0 || m_fifo.size() > 0));
                chk("fifo_level", fifo_level, m_fifo.size());
                chk("tx_ready", tx_ready, m_fifo.size() < FIFO_DEPTH);
            end
        end
    end

    always @(negedge clk) begin
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        if (!tx_ready) saw_full = 1;
    end

    task automatic push(input logic [DATA_W-1:0] w);
        int n = 0;
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1;
        while (!tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("push_timeout", 0, 1);
        @(posedge clk);
        #1 tx_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (tx_busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("idle_timeout", 0, 1);
    endtask

    // bits[0] is the start bit; every bit is expected to last d cycles.
    task automatic frame_check(input string name, input logic [15:0] bits, input int n, input int d);
        int k = 0;
        @(negedge clk);
        while (txd !== 1'b0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) begin
            chk({name, "_start_timeout"}, 0, 1);
            return;
        end
        for (int m = 0; m < n * d; m++) begin
            if (m % d == d / 2) chk($sformatf("%s_bit%0d", name, m / d), txd, bits[m / d]);
            if (m == n * d - 1) chk({name, "_busy_last"}, tx_busy, 1);
            @(negedge clk);
        end
        chk({name, "_busy_end"}, tx_busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", tx_ready, 1);

        // 0xA5, divisor 4, 8N1: 10 bits of 4 clk
        push(8'hA5);
        frame_check("t1", {1'b1, 8'hA5, 1'b0}, 10, 4);

        // 0x07 with even then odd parity, two stop bits, divisor 3: 36 clk frames
        @(negedge clk);
        cfg_divisor = 3; cfg_parity = 2'b01; cfg_stop2 = 1;
        push(8'h07);
        frame_check("t2e", {2'b11, 1'b1, 8'h07, 1'b0}, 12, 3);
        @(negedge clk);
        cfg_parity = 2'b10;
        push(8'h07);
        frame_check("t2o", {2'b11, 1'b0, 8'h07, 1'b0}, 12, 3);

        // Overfill with a producer that honours tx_ready
        @(negedge clk);
        cfg_divisor = 2; cfg_parity = 0; cfg_stop2 = 0;
        max_lvl = 0; saw_full = 0;
        for (int i = 0; i < FIFO_DEPTH + 2; i++) push(DATA_W'(8'h40 + i));
        chk("t3_max_level", max_lvl, FIFO_DEPTH);
        chk("t3_ready_dropped", saw_full, 1);
        wait_idle();

        // Config change mid-frame only affects the next frame
        @(negedge clk);
        cfg_divisor = 4; cfg_parity = 2'b01;
        push(8'h3C);
        repeat (12) @(negedge clk);
        cfg_divisor = 8; cfg_parity = 2'b10;
        push(8'h5A);
        wait_idle();

        // Reset in the middle of a data bit with 3 words queued
        @(negedge clk);
        cfg_divisor = 4; cfg_parity = 0;
        for (int i = 0; i < 4; i++) push(DATA_W'(8'h00 + i));
        repeat (22) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("t5_txd", txd, 1);
        chk("t5_level", fifo_level, 0);
        chk("t5_busy", tx_busy, 0);
        chk("t5_ready", tx_ready, 1);
        @(negedge clk);
        rst = 0;
        push(8'hC3);
        frame_check("t5", {1'b1, 8'hC3, 1'b0}, 10, 4);

        // Divisors 0 and 1 behave as 2
        @(negedge clk);
        cfg_divisor = 0;
        push(8'hA5);
        frame_check("t6d0", {1'b1, 8'hA5, 1'b0}, 10, 2);
        @(negedge clk);
        cfg_divisor = 1;
        push(8'h5A);
        frame_check("t6d1", {1'b1, 8'h5A, 1'b0}, 10, 2);

        // Push on the same edge the engine pops, with one word queued
        @(negedge clk);
        cfg_divisor = 2;
        push(8'h11);
        push(8'h22);
        begin
            int n = 0;
            @(negedge clk);
            while (!(m_line.size() == 1 && m_fifo.size() == 1) && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) chk("t6_sync_timeout", 0, 1);
            tx_data = 8'h33; tx_valid = 1;
            @(posedge clk);
            #1 tx_valid = 0;
            chk("t6_pushpop_level", fifo_level, 1);
        end
        wait_idle();

        // Random traffic, including a producer that sometimes ignores tx_ready
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            tx_valid = ($urandom % 4) == 0;
            tx_data  = DATA_W'($urandom);
            if ($urandom % 150 == 0) begin
                cfg_divisor = DIV_W'($urandom % 5);
                cfg_parity  = 2'($urandom);
                cfg_stop2   = 1'($urandom);
            end
        end
        @(negedge clk);
        tx_valid = 0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
